// File: rtl/program_pkg.sv
// Shared types and default sizing for the program loader memory.
package program_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_DONE    = 2'd3
    } load_state_e;

endpackage

// File: rtl/program_ram.sv
// Simple dual-port, synchronous-read, read-first RAM; no reset so it maps to block RAM.
module program_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Non-blocking read and write in one block give old data on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/program_loader_mem.sv
// Program memory with a direct word-write port and a little-endian byte-stream loader.
// Handshake: a byte moves on any cycle where ld_valid and ld_ready are both high.
module program_loader_mem
    import program_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output load_state_e       dbg_state
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    load_state_e       state;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] asm_word;
    logic              end_latched;
    logic              rd_seen;
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              accept;

    assign accept    = ld_ready && ld_valid;
    assign dbg_state = state;

    // Commit owns the write port; direct writes only land while the loader is idle.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (state == ST_COMMIT) begin
            ram_we    = 1'b1;
            ram_waddr = addr;
            ram_wdata = asm_word;
        end else if (wr_en && !load_busy) begin
            ram_we = 1'b1;
        end
    end

    program_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (rd_en),
        .raddr(rd_addr),
        .rdata(ram_q)
    );

    // The RAM output register has no reset, so rd_data is masked until the first read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_seen <= 1'b0;
        else if (rd_en) rd_seen <= 1'b1;
    end

    assign rd_data = rd_seen ? ram_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr        <= '0;
            idx         <= '0;
            asm_word    <= '0;
            end_latched <= 1'b0;
            ld_ready    <= 1'b0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            load_count  <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state       <= ST_COLLECT;
                        addr        <= '0;
                        idx         <= '0;
                        asm_word    <= '0;
                        load_count  <= '0;
                        end_latched <= 1'b0;
                        ld_ready    <= 1'b1;
                        load_busy   <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (accept) asm_word[8*int'(idx) +: 8] <= ld_byte;
                    if (load_end) end_latched <= 1'b1;
                    // The assembly register starts each word at zero, so an early end is zero-filled.
                    if (accept && idx == LAST_IDX) begin
                        state    <= ST_COMMIT;
                        ld_ready <= 1'b0;
                    end else if (load_end) begin
                        ld_ready <= 1'b0;
                        if (idx == '0 && !accept) begin
                            state     <= ST_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state <= ST_COMMIT;
                        end
                    end else if (accept) begin
                        idx <= idx + IDX_ONE;
                    end
                end
                ST_COMMIT: begin
                    addr       <= addr + ADDR_ONE;
                    load_count <= load_count + CNT_ONE;
                    idx        <= '0;
                    asm_word   <= '0;
                    if (addr == '1 || end_latched) begin
                        state     <= ST_DONE;
                        load_done <= 1'b1;
                    end else begin
                        state    <= ST_COLLECT;
                        ld_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    load_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader_mem.sv
// Directed bench for program_loader_mem with immediate-assertion checks.
module tb_program_loader_mem;
    import program_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          load_start;
    logic          load_end;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          load_busy;
    logic          load_done;
    logic [AW:0]   load_count;
    load_state_e   dbg_state;

    int vectors = 0;
    int miss    = 0;

    program_loader_mem #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load_start(load_start),
        .load_end  (load_end),
        .ld_valid  (ld_valid),
        .ld_byte   (ld_byte),
        .ld_ready  (ld_ready),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_count(load_count),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (!ld_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("ld_ready_wait", 64'(ld_ready), 64'd1);
        ld_valid = 1'b1;
        ld_byte  = b;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        rd_addr = a;
        rd_en   = 1'b1;
        step();
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    function automatic logic [7:0] pb(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    function automatic logic [DW-1:0] pw(input int w);
        return {pb(4*w+3), pb(4*w+2), pb(4*w+1), pb(4*w)};
    endfunction

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b0; rd_addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        load_start = 1'b0; load_end = 1'b0; ld_valid = 1'b0; ld_byte = '0;
        step(); step();
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_busy", 64'(load_busy), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_count", 64'(load_count), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk) rst_n = 1'b1;
        step();

        // Direct write and read back with hold
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0;
        rd(8'd5, d);
        chk("direct_rd5", 64'(d), 64'hDEADBEEF);
        rd_addr = 8'd6;
        step();
        chk("rd_hold", 64'(rd_data), 64'hDEADBEEF);

        // Same-address read and write returns old data
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'h12345678;
        rd_en = 1'b1; rd_addr = 8'd5;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rdw_old", 64'(rd_data), 64'hDEADBEEF);
        rd(8'd5, d);
        chk("rdw_new", 64'(d), 64'h12345678);

        // Eight-byte load, then load_end at a word boundary
        pulse_start();
        chk("l8_ready", 64'(ld_ready), 64'd1);
        chk("l8_busy", 64'(load_busy), 64'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("l8_commit0", 64'(dbg_state), 64'(ST_COMMIT));
        chk("l8_commit_ready", 64'(ld_ready), 64'd0);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        step();
        chk("l8_count", 64'(load_count), 64'd2);
        chk("l8_collect", 64'(dbg_state), 64'(ST_COLLECT));
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        chk("l8_done_state", 64'(dbg_state), 64'(ST_DONE));
        chk("l8_done_pulse", 64'(load_done), 64'd1);
        chk("l8_done_count", 64'(load_count), 64'd2);
        step();
        chk("l8_done_clear", 64'(load_done), 64'd0);
        chk("l8_idle_busy", 64'(load_busy), 64'd0);
        rd(8'd0, d);
        chk("l8_mem0", 64'(d), 64'h44332211);
        rd(8'd1, d);
        chk("l8_mem1", 64'(d), 64'h88776655);

        // Partial word with load_end zero-fills
        pulse_start();
        chk("l3_count_clr", 64'(load_count), 64'd0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        load_end = 1'b1;
        step();
        load_end = 1'b0;
        chk("l3_commit", 64'(dbg_state), 64'(ST_COMMIT));
        step();
        chk("l3_done_pulse", 64'(load_done), 64'd1);
        chk("l3_count", 64'(load_count), 64'd1);
        step();
        chk("l3_done_once", 64'(load_done), 64'd0);
        rd(8'd0, d);
        chk("l3_mem0", 64'(d), 64'h00CCBBAA);
        rd(8'd1, d);
        chk("l3_mem1_kept", 64'(d), 64'h88776655);

        // Byte accepted in the same cycle as load_end
        pulse_start();
        send_byte(8'h01);
        ld_valid = 1'b1; ld_byte = 8'h02; load_end = 1'b1;
        step();
        ld_valid = 1'b0; load_end = 1'b0;
        chk("le_commit", 64'(dbg_state), 64'(ST_COMMIT));
        step();
        chk("le_done", 64'(load_done), 64'd1);
        chk("le_count", 64'(load_count), 64'd1);
        step();
        rd(8'd0, d);
        chk("le_mem0", 64'(d), 64'h00000201);

        // Full-depth stream stops by itself after the last address
        pulse_start();
        for (int i = 0; i < 1024; i++) send_byte(pb(i));
        chk("full_commit", 64'(dbg_state), 64'(ST_COMMIT));
        step();
        chk("full_done", 64'(load_done), 64'd1);
        chk("full_count", 64'(load_count), 64'd256);
        step();
        chk("full_idle", 64'(load_busy), 64'd0);
        ld_valid = 1'b1; ld_byte = 8'h5A;
        chk("full_after_ready", 64'(ld_ready), 64'd0);
        step();
        ld_valid = 1'b0;
        chk("full_after_count", 64'(load_count), 64'd256);
        rd(8'd0, d);
        chk("full_mem0", 64'(d), 64'(pw(0)));
        rd(8'd100, d);
        chk("full_mem100", 64'(d), 64'(pw(100)));
        rd(8'd255, d);
        chk("full_mem255", 64'(d), 64'(pw(255)));

        // Reset mid-load; direct write while busy is dropped
        pulse_start();
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'hCAFEF00D;
        step();
        wr_en = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        pulse_start();
        for (int i = 6; i <= 10; i++) send_byte(8'(i));
        chk("mid_busy", 64'(load_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("mid_rst_ready", 64'(ld_ready), 64'd0);
        chk("mid_rst_busy", 64'(load_busy), 64'd0);
        chk("mid_rst_done", 64'(load_done), 64'd0);
        chk("mid_rst_count", 64'(load_count), 64'd0);
        chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        rd(8'd0, d);
        chk("mid_mem0", 64'(d), 64'h04030201);
        rd(8'd1, d);
        chk("mid_mem1", 64'(d), 64'h08070605);
        rd(8'd2, d);
        chk("mid_mem2", 64'(d), 64'(pw(2)));
        rd(8'd3, d);
        chk("mid_mem3_drop", 64'(d), 64'(pw(3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
